// File: rtl/usb_link_state.sv
// USB device link-state tracker: bus reset, suspend, host resume and remote wakeup.
// Every output is registered; tx_en is cleared asynchronously by rst_n.
module usb_link_state #(
   parameter int unsigned SUSPEND_CYC  = 144000,
   parameter int unsigned RESET_CYC    = 480000,
   parameter int unsigned RESUME_CYC   = 480000,
   parameter int unsigned WAKE_DLY_CYC = 240000,
   parameter int unsigned CNT_W        = $clog2(
      (((SUSPEND_CYC > RESET_CYC) ? SUSPEND_CYC : RESET_CYC) >
       ((RESUME_CYC > WAKE_DLY_CYC) ? RESUME_CYC : WAKE_DLY_CYC)) ?
       ((SUSPEND_CYC > RESET_CYC) ? SUSPEND_CYC : RESET_CYC) :
       ((RESUME_CYC > WAKE_DLY_CYC) ? RESUME_CYC : WAKE_DLY_CYC)) + 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_dp,
   input  logic       rx_dn,
   input  logic       rx_activity,
   input  logic       wake_ena,
   input  logic       wake_req,
   output logic [2:0] state,
   output logic       usb_rst,
   output logic       suspend,
   output logic       tx_dp,
   output logic       tx_dn,
   output logic       tx_en,
   output logic       evt_reset,
   output logic       evt_suspend,
   output logic       evt_resume,
   output logic       evt_wake_rej
);

   typedef enum logic [2:0] {
      ST_RESET    = 3'd0,
      ST_ACTIVE   = 3'd1,
      ST_SUSPEND  = 3'd2,
      ST_RES_HOST = 3'd3,
      ST_RES_DRV  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] L_RST_HIT   = CNT_W'(RESET_CYC);
   localparam logic [CNT_W-1:0] L_RST_SAT   = CNT_W'(RESET_CYC + 1);
   localparam logic [CNT_W-1:0] L_IDLE_LAST = CNT_W'(SUSPEND_CYC - 1);
   localparam logic [CNT_W-1:0] L_WAKE_MIN  = CNT_W'(WAKE_DLY_CYC);
   localparam logic [CNT_W-1:0] L_DRV_LAST  = CNT_W'(RESUME_CYC - 1);
   localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_rst_cnt;
   logic [CNT_W-1:0] w_rst_cnt_nxt;
   logic [CNT_W-1:0] r_idle_cnt;
   logic [CNT_W-1:0] w_idle_cnt_nxt;
   logic             w_se0;
   logic             w_j;
   logic             w_k;
   logic             w_idle;
   logic             w_rst_hit;
   logic             w_wake_ok;
   logic             w_evt_reset;
   logic             w_evt_suspend;
   logic             w_evt_resume;
   logic             r_usb_rst;
   logic             r_suspend;
   logic             r_tx_en;
   logic             r_tx_dp;
   logic             r_tx_dn;
   logic             r_evt_reset;
   logic             r_evt_suspend;
   logic             r_evt_resume;
   logic             r_evt_wake_rej;

   assign w_se0  = ~rx_dp & ~rx_dn;
   assign w_j    =  rx_dp & ~rx_dn;
   assign w_k    = ~rx_dp &  rx_dn;
   assign w_idle = w_j & ~rx_activity;

   // Counter saturates one past the threshold so the hit fires only once per SE0 run
   assign w_rst_hit = (r_state != ST_RES_DRV) && (r_rst_cnt == L_RST_HIT);

   assign w_wake_ok = wake_req && wake_ena && (r_state == ST_SUSPEND) &&
                      (r_idle_cnt >= L_WAKE_MIN) && !w_k && !w_rst_hit;

   always_comb begin
      w_rst_cnt_nxt = '0;
      if (r_state != ST_RES_DRV && w_se0) begin
         w_rst_cnt_nxt = (r_rst_cnt == L_RST_SAT) ? r_rst_cnt : r_rst_cnt + L_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RESET;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The idle counter doubles as suspended-time and resume-drive timer
   always_comb begin
      w_state_nxt    = r_state;
      w_idle_cnt_nxt = r_idle_cnt;
      w_evt_reset    = 1'b0;
      w_evt_suspend  = 1'b0;
      w_evt_resume   = 1'b0;
      if (w_rst_hit) begin
         w_state_nxt    = ST_RESET;
         w_idle_cnt_nxt = '0;
         w_evt_reset    = 1'b1;
      end else begin
         case (r_state)
            ST_RESET: begin
               w_idle_cnt_nxt = '0;
               if (!w_se0) w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (!w_idle) begin
                  w_idle_cnt_nxt = '0;
               end else if (r_idle_cnt == L_IDLE_LAST) begin
                  w_state_nxt    = ST_SUSPEND;
                  w_idle_cnt_nxt = '0;
                  w_evt_suspend  = 1'b1;
               end else begin
                  w_idle_cnt_nxt = r_idle_cnt + L_ONE;
               end
            end
            ST_SUSPEND: begin
               if (r_idle_cnt != '1) w_idle_cnt_nxt = r_idle_cnt + L_ONE;
               if (w_k) begin
                  w_state_nxt = ST_RES_HOST;
               end else if (w_wake_ok) begin
                  w_state_nxt    = ST_RES_DRV;
                  w_idle_cnt_nxt = '0;
               end
            end
            ST_RES_DRV: begin
               if (r_idle_cnt == L_DRV_LAST) begin
                  w_state_nxt    = ST_RES_HOST;
                  w_idle_cnt_nxt = '0;
               end else begin
                  w_idle_cnt_nxt = r_idle_cnt + L_ONE;
               end
            end
            ST_RES_HOST: begin
               if (!w_k) begin
                  w_state_nxt    = ST_ACTIVE;
                  w_idle_cnt_nxt = '0;
                  w_evt_resume   = 1'b1;
               end
            end
            default: begin
               w_state_nxt    = ST_RESET;
               w_idle_cnt_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rst_cnt      <= '0;
         r_idle_cnt     <= '0;
         r_usb_rst      <= 1'b1;
         r_suspend      <= 1'b0;
         r_tx_en        <= 1'b0;
         r_tx_dp        <= 1'b0;
         r_tx_dn        <= 1'b0;
         r_evt_reset    <= 1'b0;
         r_evt_suspend  <= 1'b0;
         r_evt_resume   <= 1'b0;
         r_evt_wake_rej <= 1'b0;
      end else begin
         r_rst_cnt      <= w_rst_cnt_nxt;
         r_idle_cnt     <= w_idle_cnt_nxt;
         r_usb_rst      <= (w_state_nxt == ST_RESET);
         r_suspend      <= (w_state_nxt == ST_SUSPEND) || (w_state_nxt == ST_RES_HOST) ||
                           (w_state_nxt == ST_RES_DRV);
         r_tx_en        <= (w_state_nxt == ST_RES_DRV);
         r_tx_dp        <= 1'b0;
         r_tx_dn        <= (w_state_nxt == ST_RES_DRV);
         r_evt_reset    <= w_evt_reset;
         r_evt_suspend  <= w_evt_suspend;
         r_evt_resume   <= w_evt_resume;
         r_evt_wake_rej <= wake_req & ~w_wake_ok;
      end
   end

   assign state        = r_state;
   assign usb_rst      = r_usb_rst;
   assign suspend      = r_suspend;
   assign tx_en        = r_tx_en;
   assign tx_dp        = r_tx_dp;
   assign tx_dn        = r_tx_dn;
   assign evt_reset    = r_evt_reset;
   assign evt_suspend  = r_evt_suspend;
   assign evt_resume   = r_evt_resume;
   assign evt_wake_rej = r_evt_wake_rej;

endmodule

// File: tb/tb_usb_link_state.sv
// Table-driven bench for usb_link_state with short timing parameters.
// Each vector holds one cycle of inputs and the packed outputs expected after that edge.
module tb_usb_link_state;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_dp, rx_dn, rx_activity, wake_ena, wake_req;
   logic [2:0] state;
   logic       usb_rst, suspend, tx_dp, tx_dn, tx_en;
   logic       evt_reset, evt_suspend, evt_resume, evt_wake_rej;
   logic [11:0] got;

   always #5 clk = ~clk;

   usb_link_state #(
      .SUSPEND_CYC  (20),
      .RESET_CYC    (10),
      .RESUME_CYC   (8),
      .WAKE_DLY_CYC (5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_dp        (rx_dp),
      .rx_dn        (rx_dn),
      .rx_activity  (rx_activity),
      .wake_ena     (wake_ena),
      .wake_req     (wake_req),
      .state        (state),
      .usb_rst      (usb_rst),
      .suspend      (suspend),
      .tx_dp        (tx_dp),
      .tx_dn        (tx_dn),
      .tx_en        (tx_en),
      .evt_reset    (evt_reset),
      .evt_suspend  (evt_suspend),
      .evt_resume   (evt_resume),
      .evt_wake_rej (evt_wake_rej)
   );

   assign got = {state, usb_rst, suspend, tx_en, tx_dp, tx_dn,
                 evt_reset, evt_suspend, evt_resume, evt_wake_rej};

   typedef struct {
      logic [1:0]  line;
      logic        act;
      logic        wena;
      logic        wreq;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_bad = 0;

   localparam logic [1:0] LJ = 2'b10, LK = 2'b01, L0 = 2'b00, L1 = 2'b11;
   // {state, usb_rst, suspend, tx_en, tx_dp, tx_dn, ev_rst, ev_sus, ev_rsm, ev_rej}
   localparam logic [11:0] XR = {3'd0, 1'b1, 8'b0};
   localparam logic [11:0] XA = {3'd1, 9'b0};
   localparam logic [11:0] XS = {3'd2, 1'b0, 1'b1, 7'b0};
   localparam logic [11:0] XH = {3'd3, 1'b0, 1'b1, 7'b0};
   localparam logic [11:0] XD = {3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0};
   localparam logic [11:0] EV_RST = 12'h008, EV_SUS = 12'h004, EV_RSM = 12'h002, EV_REJ = 12'h001;

   function automatic void add(input int n, input logic [1:0] ln, input logic act,
                               input logic wena, input logic wreq, input logic [11:0] e);
      for (int i = 0; i < n; i++) tbl.push_back('{ln, act, wena, wreq, e});
   endfunction

   // Activity pulse zeroes the idle count, then exactly 20 idle cycles reach suspend
   function automatic void add_to_suspend();
      add(1, LJ, 1'b1, 1'b0, 1'b0, XA);
      add(19, LJ, 1'b0, 1'b0, 1'b0, XA);
      add(1, LJ, 1'b0, 1'b0, 1'b0, XS | EV_SUS);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int idx, input logic [11:0] e);
      n_vec++;
      if (got !== e) begin
         n_bad++;
         $display("FAIL %s vec %0d: got %b expected %b", nm, idx, got, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      // power-on release with J, then SE0 just short of and at the reset threshold
      add(1, LJ, 0, 0, 0, XA);
      add(9, L0, 0, 0, 0, XA);
      add(1, LJ, 0, 0, 0, XA);
      add(10, L0, 0, 0, 0, XA);
      add(1, L0, 0, 0, 0, XR | EV_RST);
      add(2, L0, 0, 0, 0, XR);
      add(1, LJ, 0, 0, 0, XA);
      // SE1 is neither J nor K and must break an idle run
      add(10, LJ, 0, 0, 0, XA);
      add(1, L1, 0, 0, 0, XA);
      // activity on the 20th idle cycle blocks suspend
      add(19, LJ, 0, 0, 0, XA);
      add(1, LJ, 1, 0, 0, XA);
      add(19, LJ, 0, 0, 0, XA);
      add(1, LJ, 0, 0, 0, XS | EV_SUS);
      // wake rejected at 3, 4 suspended cycles and with enable low, accepted at 6
      add(3, LJ, 0, 0, 0, XS);
      add(1, LJ, 0, 1, 1, XS | EV_REJ);
      add(1, LJ, 0, 1, 1, XS | EV_REJ);
      add(1, LJ, 0, 0, 1, XS | EV_REJ);
      add(1, LJ, 0, 1, 1, XD);
      // K drive for 8 cycles total; SE0 during drive is ignored and not counted
      add(3, L0, 0, 0, 0, XD);
      add(1, L0, 0, 1, 1, XD | EV_REJ);
      add(3, L0, 0, 0, 0, XD);
      add(1, L0, 0, 0, 0, XH);
      add(1, L0, 0, 0, 0, XA | EV_RSM);
      add(8, L0, 0, 0, 0, XA);
      add(1, LJ, 0, 0, 0, XA);
      // host resume: K x5, SE0, J
      add_to_suspend();
      add(5, LK, 0, 0, 0, XH);
      add(1, L0, 0, 0, 0, XA | EV_RSM);
      add(2, LJ, 0, 0, 0, XA);
      add(1, LJ, 0, 1, 1, XA | EV_REJ);
      // bus reset in suspend wins over an otherwise valid wake request
      add_to_suspend();
      add(10, L0, 0, 0, 0, XS);
      add(1, L0, 0, 1, 1, XR | EV_RST | EV_REJ);
      add(1, LJ, 0, 0, 0, XA);
      // wake accepted at exactly the minimum suspended time, then part of the drive
      add_to_suspend();
      add(5, LJ, 0, 0, 0, XS);
      add(1, LJ, 0, 1, 1, XD);
      add(3, LJ, 0, 0, 0, XD);

      rst_n = 1'b0;
      {rx_dp, rx_dn} = LJ;
      rx_activity = 1'b0;
      wake_ena = 1'b0;
      wake_req = 1'b0;
      tick();
      tick();
      chk("por", 0, XR);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         {rx_dp, rx_dn} = tbl[i].line;
         rx_activity    = tbl[i].act;
         wake_ena       = tbl[i].wena;
         wake_req       = tbl[i].wreq;
         tick();
         chk("table", i, tbl[i].exp);
      end

      // asynchronous reset in the middle of the resume drive
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst", 0, XR);
      {rx_dp, rx_dn} = LJ;
      wake_ena = 1'b0;
      wake_req = 1'b0;
      tick();
      chk("rst_hold", 0, XR);
      rst_n = 1'b1;
      tick();
      chk("rst_release", 0, XA);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
